// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: request/serial-line bundle for uart_tx_serializer.
//   P_Data       parallel byte to send
//   Data_valid   request strobe
//   Parity_EN    1 = insert parity bit
//   Parity_type  0 = even, 1 = odd
//   Prescale     CLK cycles per bit (values < 4 act as 4)
//   S_Data       serial line, idle high
//   busy         frame in flight
//   hold_full    holding register occupied (only with UART_TX_HOLD_REG_EN)
// master: request side (drives byte/config), slave: the serializer.
interface uart_tx_serializer_if #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 5
);
  logic [DATA_WIDTH-1:0]     P_Data;
  logic                      Data_valid;
  logic                      Parity_EN;
  logic                      Parity_type;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      S_Data;
  logic                      busy;
`ifdef UART_TX_HOLD_REG_EN
  logic                      hold_full;

  modport master (
    output P_Data, Data_valid, Parity_EN, Parity_type, Prescale,
    input  S_Data, busy, hold_full
  );
  modport slave (
    input  P_Data, Data_valid, Parity_EN, Parity_type, Prescale,
    output S_Data, busy, hold_full
  );
`else
  modport master (
    output P_Data, Data_valid, Parity_EN, Parity_type, Prescale,
    input  S_Data, busy
  );
  modport slave (
    input  P_Data, Data_valid, Parity_EN, Parity_type, Prescale,
    output S_Data, busy
  );
`endif
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter. Frames a parallel byte as
// start(0), data LSB-first, optional parity, stop(1), each bit held for
// Prescale CLK cycles (minimum 4). S_Data is registered and idles high.
// Ports:
//   CLK    system clock, rising edge
//   Reset  synchronous, active-high
//   bus    uart_tx_serializer_if.slave (P_Data, Data_valid, Parity_EN,
//          Parity_type, Prescale in; S_Data, busy [, hold_full] out)
// Optional build macro UART_TX_HOLD_REG_EN adds a 1-deep holding register
// (byte + config) that is launched with no idle gap at the end of the
// current stop bit, and exposes hold_full.
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  Reset,
  uart_tx_serializer_if.slave   bus
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      par_en_q, par_en_d;
  logic                      par_bit_q, par_bit_d;
  logic                      s_data_q, s_data_d;
  logic                      busy_q, busy_d;

  logic [PRESCALE_WIDTH-1:0] presc_in;
  logic                      par_in;
  logic                      bit_end;
  logic                      last_data;
  logic                      launch_new;

  assign presc_in  = (bus.Prescale < PRESCALE_WIDTH'(4)) ? PRESCALE_WIDTH'(4) : bus.Prescale;
  assign par_in    = bus.Parity_type ? ~^bus.P_Data : ^bus.P_Data;
  assign bit_end   = (cnt_q == presc_q - PRESCALE_WIDTH'(1));
  assign last_data = (idx_q == IDX_W'(DATA_WIDTH - 1));

`ifdef UART_TX_HOLD_REG_EN
  logic [DATA_WIDTH-1:0]     hold_data_q, hold_data_d;
  logic [PRESCALE_WIDTH-1:0] hold_presc_q, hold_presc_d;
  logic                      hold_par_en_q, hold_par_en_d;
  logic                      hold_par_bit_q, hold_par_bit_d;
  logic                      hold_full_q, hold_full_d;
  logic                      launch_held;

  assign bus.hold_full = hold_full_q;
`endif

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      presc_q   <= PRESCALE_WIDTH'(4);
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      s_data_q  <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_HOLD_REG_EN
      hold_data_q    <= '0;
      hold_presc_q   <= PRESCALE_WIDTH'(4);
      hold_par_en_q  <= 1'b0;
      hold_par_bit_q <= 1'b0;
      hold_full_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      s_data_q  <= s_data_d;
      busy_q    <= busy_d;
`ifdef UART_TX_HOLD_REG_EN
      hold_data_q    <= hold_data_d;
      hold_presc_q   <= hold_presc_d;
      hold_par_en_q  <= hold_par_en_d;
      hold_par_bit_q <= hold_par_bit_d;
      hold_full_q    <= hold_full_d;
`endif
    end
  end

  // Next-state and frame latch logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    presc_d    = presc_q;
    idx_d      = idx_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    launch_new = 1'b0;
`ifdef UART_TX_HOLD_REG_EN
    hold_data_d    = hold_data_q;
    hold_presc_d   = hold_presc_q;
    hold_par_en_d  = hold_par_en_q;
    hold_par_bit_d = hold_par_bit_q;
    hold_full_d    = hold_full_q;
    launch_held    = 1'b0;
`endif

    if (state_q != ST_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + PRESCALE_WIDTH'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
`ifdef UART_TX_HOLD_REG_EN
        // An entry captured on the final stop edge waits here one cycle.
        if (hold_full_q) begin
          launch_held = 1'b1;
        end else if (bus.Data_valid) begin
          launch_new = 1'b1;
        end
`else
        if (bus.Data_valid) begin
          launch_new = 1'b1;
        end
`endif
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (last_data) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
`ifdef UART_TX_HOLD_REG_EN
          if (hold_full_q) begin
            launch_held = 1'b1;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef UART_TX_HOLD_REG_EN
    if (bus.Data_valid && busy_q && !hold_full_q) begin
      hold_data_d    = bus.P_Data;
      hold_presc_d   = presc_in;
      hold_par_en_d  = bus.Parity_EN;
      hold_par_bit_d = par_in;
      hold_full_d    = 1'b1;
    end
    if (launch_held) begin
      state_d     = ST_START;
      cnt_d       = '0;
      idx_d       = '0;
      data_d      = hold_data_q;
      presc_d     = hold_presc_q;
      par_en_d    = hold_par_en_q;
      par_bit_d   = hold_par_bit_q;
      hold_full_d = 1'b0;
    end
`endif

    if (launch_new) begin
      state_d   = ST_START;
      cnt_d     = '0;
      idx_d     = '0;
      data_d    = bus.P_Data;
      presc_d   = presc_in;
      par_en_d  = bus.Parity_EN;
      par_bit_d = par_in;
    end
  end

  // Registered outputs are computed from the next state so S_Data and busy
  // change on the same edge the FSM moves (start bit appears on the accept edge).
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    s_data_d = 1'b1;
    unique case (state_d)
      ST_START:  s_data_d = 1'b0;
      ST_DATA:   s_data_d = data_d[idx_d];
      ST_PARITY: s_data_d = par_bit_d;
      default:   s_data_d = 1'b1;
    endcase
  end

  assign bus.S_Data = s_data_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: compares every cycle of each
// frame against a bit-list reference model of the UART frame format.
module tb_uart_tx_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  uart_tx_serializer_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) bus ();

  uart_tx_serializer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Reference model: bit i of a frame, as defined by the UART format.
  function automatic logic model_bit(input logic [7:0] d, input logic en,
                                     input logic typ, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (en && i == 9) return typ ? ~^d : ^d;
    return 1'b1;
  endfunction

  function automatic int eff_p(input int p);
    return (p < 4) ? 4 : p;
  endfunction

  // Checks one frame that starts on the next rising edge. Inputs are
  // scrambled after the accept; an optional mid-frame request is pulsed.
  task automatic expect_frame(input logic [7:0] d, input logic en, input logic typ,
                              input int p, input int pulse_at);
    int pe;
    int n;
    pe = eff_p(p);
    n  = 10 + int'(en);
    for (int c = 0; c < pe * n; c++) begin
      @(posedge clk); #1;
      total++;
      if (bus.S_Data !== model_bit(d, en, typ, c / pe)) begin
        bad++;
        $display("FAIL sdata d=%h p=%0d cyc=%0d got=%b exp=%b", d, p, c, bus.S_Data,
                 model_bit(d, en, typ, c / pe));
      end
      total++;
      if (bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL busy_in_frame d=%h cyc=%0d got=%b exp=1", d, c, bus.busy);
      end
      if (c == 0) begin
        bus.Data_valid  = 1'b0;
        bus.P_Data      = 8'($urandom);
        bus.Parity_EN   = 1'($urandom);
        bus.Parity_type = 1'($urandom);
        bus.Prescale    = 5'($urandom);
      end
      if (pulse_at > 0 && c == pulse_at) begin
        bus.Data_valid  = 1'b1;
        bus.P_Data      = 8'hAA;
        bus.Parity_EN   = 1'b1;
        bus.Parity_type = 1'b0;
        bus.Prescale    = 5'd8;
      end
      if (pulse_at > 0 && c == pulse_at + 1) bus.Data_valid = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0 || bus.S_Data !== 1'b1) begin
      bad++;
      $display("FAIL idle_%s got busy=%b sdata=%b exp busy=0 sdata=1", tag, bus.busy, bus.S_Data);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic en, input logic typ, input int p);
    bus.P_Data      = d;
    bus.Parity_EN   = en;
    bus.Parity_type = typ;
    bus.Prescale    = 5'(p);
    bus.Data_valid  = 1'b1;
    expect_frame(d, en, typ, p, 0);
    check_idle("after_frame");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.S_Data !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got busy=%b sdata=%b exp busy=0 sdata=1", bus.busy, bus.S_Data);
    end
`ifdef UART_TX_HOLD_REG_EN
    total++;
    if (bus.hold_full !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold_full got=%b exp=0", bus.hold_full);
    end
`endif
    rst = 1'b0;
    check_idle("post_reset");
  endtask

  task automatic test_spec_vectors();
    send(8'hD5, 1'b1, 1'b0, 8);
    send(8'hFF, 1'b1, 1'b0, 8);
    send(8'hFF, 1'b1, 1'b1, 8);
    send(8'h00, 1'b0, 1'b0, 16);
  endtask

  task automatic test_prescale_bounds();
    send(8'h3C, 1'b1, 1'b1, 0);
    send(8'hC3, 1'b0, 1'b0, 3);
    send(8'h81, 1'b1, 1'b0, 4);
    send(8'h7E, 1'b1, 1'b1, 31);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 31)));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom), 1'b1, 1'(i), 4 + i);
    end
  endtask

  task automatic test_midframe_request();
    bus.P_Data      = 8'h5A;
    bus.Parity_EN   = 1'b1;
    bus.Parity_type = 1'b1;
    bus.Prescale    = 5'd8;
    bus.Data_valid  = 1'b1;
    expect_frame(8'h5A, 1'b1, 1'b1, 8, 20);
`ifdef UART_TX_HOLD_REG_EN
    total++;
    if (bus.hold_full !== 1'b1) begin
      bad++;
      $display("FAIL hold_loaded got=%b exp=1", bus.hold_full);
    end
    expect_frame(8'hAA, 1'b1, 1'b0, 8, 0);
    total++;
    if (bus.hold_full !== 1'b0) begin
      bad++;
      $display("FAIL hold_cleared got=%b exp=0", bus.hold_full);
    end
    check_idle("after_held");
`else
    for (int i = 0; i < 4; i++) check_idle("ignored_req");
`endif
  endtask

  task automatic test_reset_midframe();
    bus.P_Data      = 8'hB4;
    bus.Parity_EN   = 1'b1;
    bus.Parity_type = 1'b0;
    bus.Prescale    = 5'd8;
    bus.Data_valid  = 1'b1;
    // Frame bit 4 (data bit 3) spans cycles 32..39; reset lands inside it.
    for (int c = 0; c < 36; c++) begin
      @(posedge clk); #1;
      if (c == 0) bus.Data_valid = 1'b0;
      total++;
      if (bus.S_Data !== model_bit(8'hB4, 1'b1, 1'b0, c / 8)) begin
        bad++;
        $display("FAIL pre_reset_sdata cyc=%0d got=%b exp=%b", c, bus.S_Data,
                 model_bit(8'hB4, 1'b1, 1'b0, c / 8));
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.S_Data !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL midframe_reset got busy=%b sdata=%b exp busy=0 sdata=1", bus.busy, bus.S_Data);
    end
    rst = 1'b0;
    check_idle("release1");
    check_idle("release2");
    send(8'h69, 1'b1, 1'b1, 8);
  endtask

  initial begin
    bus.P_Data      = '0;
    bus.Data_valid  = 1'b0;
    bus.Parity_EN   = 1'b0;
    bus.Parity_type = 1'b0;
    bus.Prescale    = 5'd8;
    test_reset();
    test_spec_vectors();
    test_prescale_bounds();
    test_random();
    test_back_to_back();
    test_midframe_request();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
